// File: rtl/button_evt_pkg.sv
// Shared types for the button event controller: event kinds, per-button FSM states
// and the event record carried on the output stream.
package button_evt_pkg;

  typedef enum logic [1:0] {
    EVT_SHORT    = 2'd0,
    EVT_LONG     = 2'd1,
    EVT_REPEAT   = 2'd2,
    EVT_REL_LONG = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_t;

  // Wide enough for any practical button count; consumers narrow it to their index width.
  localparam int EVT_BTN_W = 8;

  typedef struct packed {
    logic [EVT_BTN_W-1:0] btn;
    evt_type_t            typ;
  } btn_evt_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with a full flag on the write side and a valid/ready read side.
// DEPTH must be a power of two so the pointers wrap naturally.
module evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO refuses the push even if the head is popped on the same edge.
  assign w_push = i_push & ~o_full;
  assign w_pop  = o_valid & i_ready;

  // NOTE: storage is deliberately not reset; the count/pointers alone define which
  // entries are valid, so resetting the array would only add reset fan-out.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced button levels -> SHORT/LONG/REPEAT/REL_LONG event stream via per-button FSMs,
// a round-robin arbiter and an event FIFO. Define BTN_AUTOREPEAT_EN to enable REPEAT events.
module button_event_ctrl
  import button_evt_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_BTN-1:0]         btn_clean_in,
  output logic                       evt_valid_out,
  input  logic                       evt_ready_in,
  output logic [$clog2(NUM_BTN)-1:0] evt_btn_out,
  output evt_type_t                  evt_type_out,
  output logic [NUM_BTN-1:0]         held_out,
  output logic                       overflow_out
);

  localparam int BTN_W = $clog2(NUM_BTN);
  localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [NUM_BTN-1:0] w_pending;
  logic [NUM_BTN-1:0] w_grant_oh;
  logic [NUM_BTN-1:0] w_drop;
  evt_type_t          w_type [NUM_BTN];
  logic               w_grant_any;
  logic [BTN_W-1:0]   w_grant_idx;
  logic [BTN_W+1:0]   w_push_data;
  logic [BTN_W+1:0]   w_fifo_head;
  logic               w_fifo_full;
  logic [BTN_W-1:0]   r_rr;
  logic               r_overflow;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prev;
    logic             r_pending;
    evt_type_t        r_type;
    logic             w_emit;
    evt_type_t        w_emit_type;

    // NOTE: every output of this always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
      w_emit      = 1'b0;
      w_emit_type = EVT_SHORT;
      case (r_state)
        ST_PRESSED: begin
          // Release beats the LONG threshold when both land on the same edge.
          if (!btn_clean_in[i]) begin
            w_emit      = 1'b1;
            w_emit_type = EVT_SHORT;
          end else if (r_cnt == LONG_LAST) begin
            w_emit      = 1'b1;
            w_emit_type = EVT_LONG;
          end
        end
        ST_LONG: begin
          if (!btn_clean_in[i]) begin
            w_emit      = 1'b1;
            w_emit_type = EVT_REL_LONG;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (r_cnt == REPEAT_LAST) begin
            w_emit      = 1'b1;
            w_emit_type = EVT_REPEAT;
          end
`endif
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_prev    <= btn_clean_in[i];
        r_pending <= 1'b0;
        r_type    <= EVT_SHORT;
      end else begin
        r_prev <= btn_clean_in[i];
        case (r_state)
          ST_IDLE: begin
            if (btn_clean_in[i] && !r_prev) begin
              r_state <= ST_PRESSED;
              r_cnt   <= '0;
            end
          end
          ST_PRESSED: begin
            if (!btn_clean_in[i]) begin
              r_state <= ST_IDLE;
            end else if (r_cnt == LONG_LAST) begin
              r_state <= ST_LONG;
              r_cnt   <= '0;
            end else if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_LONG: begin
            if (!btn_clean_in[i]) begin
              r_state <= ST_IDLE;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (r_cnt == REPEAT_LAST) begin
              r_cnt <= '0;
            end else if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
`endif
          end
          default: r_state <= ST_IDLE;
        endcase

        // An event arriving while one is still pending is lost (flagged via w_drop).
        if (w_emit && !r_pending) begin
          r_pending <= 1'b1;
          r_type    <= w_emit_type;
        end else if (w_grant_oh[i]) begin
          r_pending <= 1'b0;
        end
      end
    end

    assign w_pending[i] = r_pending;
    assign w_type[i]    = r_type;
    assign w_drop[i]    = w_emit & r_pending;
    assign held_out[i]  = (r_state != ST_IDLE);
  end

  // Round-robin search starting at r_rr; no grant while the FIFO is full.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    if (!w_fifo_full) begin
      for (int k = 0; k < NUM_BTN; k++) begin
        if (!w_grant_any && w_pending[(int'(r_rr) + k) % NUM_BTN]) begin
          w_grant_any = 1'b1;
          w_grant_idx = BTN_W'((int'(r_rr) + k) % NUM_BTN);
        end
      end
    end
    if (w_grant_any) w_grant_oh[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rr       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (|w_drop) r_overflow <= 1'b1;
      if (w_grant_any) begin
        r_rr <= (w_grant_idx == BTN_W'(NUM_BTN - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign w_push_data = {w_grant_idx, w_type[w_grant_idx]};

  evt_fifo #(
    .WIDTH (BTN_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_grant_any),
    .i_data  (w_push_data),
    .o_full  (w_fifo_full),
    .o_valid (evt_valid_out),
    .i_ready (evt_ready_in),
    .o_data  (w_fifo_head)
  );

  assign evt_btn_out  = w_fifo_head[BTN_W+1:2];
  assign evt_type_out = evt_type_t'(w_fifo_head[1:0]);
  assign overflow_out = r_overflow;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a hold-time based reference model.
module tb_button_event_ctrl;
  import button_evt_pkg::*;

  localparam int NB = 2;
  localparam int LC = 20;
  localparam int RC = 5;
  localparam int FD = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic          ready;
  logic          evt_valid;
  logic [0:0]    evt_btn;
  logic [1:0]    evt_type;
  logic [NB-1:0] held;
  logic          ovf;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NUM_BTN(NB), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .btn_clean_in  (btn),
    .evt_valid_out (evt_valid),
    .evt_ready_in  (ready),
    .evt_btn_out   (evt_btn),
    .evt_type_out  (evt_type),
    .held_out      (held),
    .overflow_out  (ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks hold length since the rising edge instead of FSM state.
  bit        m_active [NB];
  int        m_h      [NB];
  bit        m_prev   [NB];
  bit        m_pend   [NB];
  evt_type_t m_ptype  [NB];
  btn_evt_t  m_q [$];
  int        m_rr;
  bit        m_ovf;
  int        cyc;

  typedef struct { int btn; int typ; int cyc; } log_t;
  log_t log_q [$];

  bit         chk_en = 1'b0;
  logic       seen_valid = 1'b0;
  logic [0:0] seen_btn;
  logic [1:0] seen_type;

  task automatic model_step();
    bit pend_pre [NB];
    int grant;
    bit has;
    evt_type_t e;
    cyc++;
    if (!rst && seen_valid && ready)
      log_q.push_back(log_t'{int'(seen_btn), int'(seen_type), cyc});
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_active[i] = 0; m_h[i] = 0; m_pend[i] = 0; m_ptype[i] = EVT_SHORT; m_prev[i] = btn[i];
      end
      m_q.delete();
      m_rr  = 0;
      m_ovf = 0;
      return;
    end
    pend_pre = m_pend;
    grant = -1;
    if (m_q.size() < FD)
      for (int k = 0; k < NB; k++)
        if (grant < 0 && m_pend[(m_rr + k) % NB]) grant = (m_rr + k) % NB;
    if (m_q.size() > 0 && ready) void'(m_q.pop_front());
    if (grant >= 0) begin
      m_q.push_back(btn_evt_t'{btn: 8'(grant), typ: m_ptype[grant]});
      m_pend[grant] = 0;
      m_rr = (grant + 1) % NB;
    end
    for (int i = 0; i < NB; i++) begin
      has = 0;
      e   = EVT_SHORT;
      if (m_active[i]) begin
        m_h[i]++;
        if (!btn[i]) begin
          has = 1;
          e   = (m_h[i] <= LC) ? EVT_SHORT : EVT_REL_LONG;
          m_active[i] = 0;
        end else if (m_h[i] == LC) begin
          has = 1; e = EVT_LONG;
        end else if (AR && m_h[i] > LC && (m_h[i] - LC) % RC == 0) begin
          has = 1; e = EVT_REPEAT;
        end
      end else if (btn[i] && !m_prev[i]) begin
        m_active[i] = 1;
        m_h[i]      = 0;
      end
      if (has) begin
        if (pend_pre[i]) m_ovf = 1;
        else begin m_pend[i] = 1; m_ptype[i] = e; end
      end
      m_prev[i] = btn[i];
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NB-1:0] hx;
    if (chk_en) begin
      for (int i = 0; i < NB; i++) hx[i] = m_active[i];
      check("valid", evt_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("evt_btn", evt_btn, m_q[0].btn);
        check("evt_type", evt_type, m_q[0].typ);
      end
      check("held", held, hx);
      check("overflow", ovf, m_ovf);
    end
    seen_valid <= chk_en && (evt_valid === 1'b1);
    seen_btn   <= evt_btn;
    seen_type  <= evt_type;
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic check_evt(input string nm, input int idx, input int b, input int t, input int c);
    if (log_q.size() > idx) begin
      check({nm, "_btn"}, log_q[idx].btn, b);
      check({nm, "_type"}, log_q[idx].typ, t);
      if (c >= 0) check({nm, "_edge"}, log_q[idx].cyc, c);
    end else begin
      check({nm, "_present"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    int rel, e0, pe;
    rst = 1'b1; btn = '0; ready = 1'b1; cyc = 0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    log_q.delete();
    check("rst_valid", evt_valid, 0);
    check("rst_held", held, 0);
    check("rst_ovf", ovf, 0);

    // 1: short press on btn0
    tick();
    btn[0] = 1'b1;
    tick();
    check("t1_held", held[0], 1);
    idle(4);
    btn[0] = 1'b0;
    rel = cyc + 1;
    tick();
    idle(5);
    check("t1_count", log_q.size(), 1);
    check_evt("t1", 0, 0, EVT_SHORT, rel + 2);
    check("t1_held_after", held, 0);

    // 2: long hold on btn1 for 32 cycles
    do_reset();
    btn[1] = 1'b1;
    e0 = cyc + 1;
    idle(32);
    btn[1] = 1'b0;
    idle(6);
    check_evt("t2_long", 0, 1, EVT_LONG, e0 + 22);
`ifdef BTN_AUTOREPEAT_EN
    check("t2_count", log_q.size(), 4);
    check_evt("t2_rep0", 1, 1, EVT_REPEAT, e0 + 27);
    check_evt("t2_rep1", 2, 1, EVT_REPEAT, e0 + 32);
    check_evt("t2_rel", 3, 1, EVT_REL_LONG, e0 + 34);
`else
    check("t2_count", log_q.size(), 2);
    check_evt("t2_rel", 1, 1, EVT_REL_LONG, e0 + 34);
`endif

    // 3: simultaneous release, round-robin from 0
    do_reset();
    btn = 2'b11;
    idle(4);
    btn = 2'b00;
    rel = cyc + 1;
    tick();
    idle(5);
    check("t3_count", log_q.size(), 2);
    check_evt("t3_a", 0, 0, EVT_SHORT, rel + 2);
    check_evt("t3_b", 1, 1, EVT_SHORT, rel + 3);

    // 4: overflow with consumer stalled
    do_reset();
    ready = 1'b0;
    repeat (6) begin
      btn[0] = 1'b1; idle(3);
      btn[0] = 1'b0; idle(3);
    end
    check("t4_none_popped", log_q.size(), 0);
    check("t4_ovf", ovf, 1);
    check("t4_valid", evt_valid, 1);
    ready = 1'b1;
    idle(10);
    check("t4_count", log_q.size(), 5);
    for (int j = 0; j < 5; j++) check_evt($sformatf("t4_e%0d", j), j, 0, EVT_SHORT, -1);
    check("t4_ovf_sticky", ovf, 1);

    // 5: reset while btn0 held
    btn[0] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    log_q.delete();
    check("t5_held_rst", held, 0);
    check("t5_ovf_rst", ovf, 0);
    idle(9);
    check("t5_held", held, 0);
    btn[0] = 1'b0;
    idle(6);
    check("t5_no_evt", log_q.size(), 0);
    check("t5_valid", evt_valid, 0);

    // 6: head held stable while not ready
    do_reset();
    ready = 1'b0;
    btn[1] = 1'b1; idle(3);
    btn[1] = 1'b0; idle(2);
    for (int j = 0; j < 10; j++) begin
      check("t6_valid", evt_valid, 1);
      check("t6_btn", evt_btn, 1);
      check("t6_type", evt_type, EVT_SHORT);
      tick();
    end
    ready = 1'b1;
    pe = cyc + 1;
    tick();
    check("t6_count", log_q.size(), 1);
    check_evt("t6", 0, 1, EVT_SHORT, pe);
    check("t6_empty", evt_valid, 0);

    // Randomized: fast toggling, then long holds, with stalled-consumer windows
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ready = ((c % 200) < 150) ? ($urandom_range(0, 3) != 0) : 1'b0;
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, (c < 1500) ? 3 : 29) == 0) btn[i] = ~btn[i];
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
